// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared constants for the decode/execute pipeline buses.
//   PIPE_DATA_W    - default operand width
//   PIPE_AW        - default register address width
//   PIPE_PAYLOAD_W - default width of the opaque instruction bundle
//   PIPE_NRD       - default number of source operands per instruction
//   PIPE_NSRC      - default number of forwarding producers
//   STALL_CNT_W    - width of the optional operand-stall counter
package pipe_pkg;

    localparam int PIPE_DATA_W    = 32;
    localparam int PIPE_AW        = 5;
    localparam int PIPE_PAYLOAD_W = 64;
    localparam int PIPE_NRD       = 2;
    localparam int PIPE_NSRC      = 3;
    localparam int STALL_CNT_W    = 32;

    typedef logic [PIPE_AW-1:0]     reg_addr_t;
    typedef logic [PIPE_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/fwd_select.sv
// fwd_select
// Resolves one source operand against NSRC priority-ordered forwarding
// producers (index 0 youngest, highest priority) or the register file.
// Ports:
//   raddr, rden          - operand register number and read enable
//   fwd_valid/ready      - per producer: writes a register / result available
//   fwd_dest, fwd_data   - per producer destination and result (packed)
//   rf_rdata             - register-file data for this operand
//   opnd_ready           - operand value is usable this cycle
//   opnd_data            - resolved operand value
module fwd_select
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int AW     = PIPE_AW,
    parameter int NSRC   = PIPE_NSRC
) (
    input  logic [AW-1:0]          raddr,
    input  logic                   rden,
    input  logic [NSRC-1:0]        fwd_valid,
    input  logic [NSRC-1:0]        fwd_ready,
    input  logic [NSRC*AW-1:0]     fwd_dest,
    input  logic [NSRC*DATA_W-1:0] fwd_data,
    input  logic [DATA_W-1:0]      rf_rdata,
    output logic                   opnd_ready,
    output logic [DATA_W-1:0]      opnd_data
);

    logic [NSRC-1:0] hit;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_hit
            assign hit[gi] = fwd_valid[gi] && (fwd_dest[gi*AW +: AW] == raddr);
        end
    endgenerate

    // Walk from oldest to youngest so the lowest matching index wins. A
    // youngest hit that is not ready blocks the operand even when an older
    // producer has the same register ready: its value would be stale.
    always_comb begin
        opnd_ready = 1'b1;
        opnd_data  = rf_rdata;
        if (!rden || (raddr == '0)) begin
            opnd_data = '0;
        end else begin
            for (int k = NSRC - 1; k >= 0; k--) begin
                if (hit[k]) begin
                    opnd_ready = fwd_ready[k];
                    opnd_data  = fwd_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/operand_fwd_stage.sv
// operand_fwd_stage
// Decode-side operand stage: one valid/allowin pipeline register holding an
// instruction bundle plus NRD source operands, each resolved from the
// register file or NSRC forwarding producers. Operands are captured into
// hold registers once resolved so later producer movement cannot alter them.
// Ports:
//   clk, resetn                      - clock, asynchronous active-low reset
//   in_valid/in_allowin/in_payload   - upstream handshake and bundle
//   in_raddr, in_rden                - source register numbers and enables
//   flush                            - discard the held instruction
//   out_valid/out_allowin/out_payload- downstream handshake and bundle
//   out_opnd                         - resolved operands (packed, op 0 at LSB)
//   rf_raddr, rf_rdata               - register-file read port (comb data)
//   fwd_valid/ready/dest/data        - forwarding producers, index 0 youngest
//   stall_cnt                        - operand-stall cycle counter, present
//                                      only when OPERAND_FWD_STALL_CNT_EN is
//                                      defined
module operand_fwd_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W    = PIPE_DATA_W,
    parameter int AW        = PIPE_AW,
    parameter int NRD       = PIPE_NRD,
    parameter int NSRC      = PIPE_NSRC,
    parameter int PAYLOAD_W = PIPE_PAYLOAD_W
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_allowin,
    input  logic [PAYLOAD_W-1:0]   in_payload,
    input  logic [NRD*AW-1:0]      in_raddr,
    input  logic [NRD-1:0]         in_rden,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_allowin,
    output logic [PAYLOAD_W-1:0]   out_payload,
    output logic [NRD*DATA_W-1:0]  out_opnd,
    output logic [NRD*AW-1:0]      rf_raddr,
    input  logic [NRD*DATA_W-1:0]  rf_rdata,
    input  logic [NSRC-1:0]        fwd_valid,
    input  logic [NSRC-1:0]        fwd_ready,
    input  logic [NSRC*AW-1:0]     fwd_dest,
    input  logic [NSRC*DATA_W-1:0] fwd_data
`ifdef OPERAND_FWD_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    logic                  valid_reg;
    logic [PAYLOAD_W-1:0]  payload_reg;
    logic [NRD*AW-1:0]     raddr_reg;
    logic [NRD-1:0]        rden_reg;
    logic [NRD-1:0]        got_reg;
    logic [NRD*DATA_W-1:0] hold_reg;

    logic [NRD-1:0]        sel_rdy;
    logic [NRD*DATA_W-1:0] sel_data;
    logic [NRD-1:0]        opnd_rdy;
    logic                  ready_go;

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_opnd
            fwd_select #(
                .DATA_W (DATA_W),
                .AW     (AW),
                .NSRC   (NSRC)
            ) u_fwd_select (
                .raddr      (raddr_reg[gi*AW +: AW]),
                .rden       (rden_reg[gi]),
                .fwd_valid  (fwd_valid),
                .fwd_ready  (fwd_ready),
                .fwd_dest   (fwd_dest),
                .fwd_data   (fwd_data),
                .rf_rdata   (rf_rdata[gi*DATA_W +: DATA_W]),
                .opnd_ready (sel_rdy[gi]),
                .opnd_data  (sel_data[gi*DATA_W +: DATA_W])
            );

            // A captured operand is frozen; only unresolved ones track producers.
            assign opnd_rdy[gi] = got_reg[gi] | sel_rdy[gi];
            assign out_opnd[gi*DATA_W +: DATA_W] = got_reg[gi] ? hold_reg[gi*DATA_W +: DATA_W]
                                                               : sel_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign ready_go    = valid_reg && (&opnd_rdy);
    assign out_valid   = ready_go && !flush;
    assign in_allowin  = (!valid_reg || (ready_go && out_allowin)) && !flush;
    assign out_payload = payload_reg;
    assign rf_raddr    = raddr_reg;

    // Flush outranks load, load outranks leave, and capture happens only
    // while the instruction stays put.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_reg   <= 1'b0;
            payload_reg <= '0;
            raddr_reg   <= '0;
            rden_reg    <= '0;
            got_reg     <= '0;
            hold_reg    <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
            got_reg   <= '0;
        end else if (in_valid && in_allowin) begin
            valid_reg   <= 1'b1;
            payload_reg <= in_payload;
            raddr_reg   <= in_raddr;
            rden_reg    <= in_rden;
            got_reg     <= '0;
        end else if (out_valid && out_allowin) begin
            valid_reg <= 1'b0;
            got_reg   <= '0;
        end else if (valid_reg) begin
            for (int i = 0; i < NRD; i++) begin
                if (sel_rdy[i] && !got_reg[i]) begin
                    got_reg[i]                     <= 1'b1;
                    hold_reg[i*DATA_W +: DATA_W]   <= sel_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef OPERAND_FWD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_reg;

    // Counts operand stalls only; downstream backpressure is not a stall here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_reg <= '0;
        end else if (valid_reg && !ready_go && !flush && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule
